// File: rtl/id_fwd_hazard_unit.sv
// ID-stage forwarding select and load/branch hazard stall unit.
// Produces per-operand forward selects, a stall/bubble pair and a saturating stall counter.
module id_fwd_hazard_unit #(
    parameter int REG_W  = 5,
    parameter int NPORTS = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    branch_id,
    input  logic [NPORTS*REG_W-1:0] src_id,
    input  logic [NPORTS-1:0]       src_used_id,
    input  logic                    RegWrite_ex,
    input  logic                    MemRead_ex,
    input  logic [REG_W-1:0]        writeReg_ex,
    input  logic                    RegWrite_mem,
    input  logic                    MemRead_mem,
    input  logic [REG_W-1:0]        writeReg_mem,
    output logic [NPORTS*2-1:0]     fwd_sel_id,
    output logic                    stall_id,
    output logic                    flush_ex,
    output logic [CNT_W-1:0]        stall_count
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q;

    logic [NPORTS-1:0] m_ex, m_mem;
    logic [REG_W-1:0]  src_k;
    logic [1:0]        port_need;
    logic [1:0]        need;

    always_comb begin
        m_ex       = '0;
        m_mem      = '0;
        src_k      = '0;
        port_need  = 2'd0;
        need       = 2'd0;
        fwd_sel_id = '0;
        for (int k = 0; k < NPORTS; k++) begin
            src_k    = src_id[k*REG_W +: REG_W];
            m_ex[k]  = src_used_id[k] & RegWrite_ex & (writeReg_ex != '0) &
                       (src_k == writeReg_ex);
            m_mem[k] = src_used_id[k] & RegWrite_mem & (writeReg_mem != '0) &
                       (src_k == writeReg_mem);

            if (!reset) begin
                if (m_ex[k])       fwd_sel_id[2*k +: 2] = 2'b10;
                else if (m_mem[k]) fwd_sel_id[2*k +: 2] = 2'b01;
                else               fwd_sel_id[2*k +: 2] = 2'b00;
            end

            // EX row takes precedence when both stages match the same operand.
            if (branch_id && m_ex[k] && MemRead_ex)        port_need = 2'd2;
            else if (branch_id && m_ex[k])                 port_need = 2'd1;
            else if (branch_id && m_mem[k] && MemRead_mem) port_need = 2'd1;
            else if (!branch_id && m_ex[k] && MemRead_ex)  port_need = 2'd1;
            else                                           port_need = 2'd0;

            if (port_need > need) need = port_need;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_id = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall_id = (need != 2'd0);
                if (need == 2'd2) begin
                    state_d = StHold;
                    cnt_d   = 2'd1;
                end
            end
            StHold: begin
                stall_id = 1'b1;
                cnt_d    = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (reset) stall_id = 1'b0;
        flush_ex = stall_id;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_id && (count_q != '1)) count_q <= count_q + CNT_W'(1);
        end
    end

    assign stall_count = count_q;

endmodule

// File: tb/tb_id_fwd_hazard_unit.sv
// Scoreboard bench for id_fwd_hazard_unit: directed scenarios then random traffic,
// checked against a cycle-level model built from the hazard and forwarding rules.
module tb_id_fwd_hazard_unit;

    localparam int REG_W  = 5;
    localparam int NPORTS = 2;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [3:0]       fwd;
        logic             stall;
        logic [CNT_W-1:0] cnt;
        logic             chk_cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic             branch_id = 1'b0;
    logic [REG_W-1:0] src_a [NPORTS];
    logic [1:0]       used = 2'b00;
    logic             rw_ex = 1'b0, mr_ex = 1'b0, rw_mem = 1'b0, mr_mem = 1'b0;
    logic [REG_W-1:0] wr_ex = '0, wr_mem = '0;
    logic [NPORTS*REG_W-1:0] src_id;
    logic [3:0]       fwd_sel_id;
    logic             stall_id, flush_ex;
    logic [CNT_W-1:0] stall_count;

    assign src_id = {src_a[1], src_a[0]};

    id_fwd_hazard_unit #(.REG_W(REG_W), .NPORTS(NPORTS), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .branch_id   (branch_id),
        .src_id      (src_id),
        .src_used_id (used),
        .RegWrite_ex (rw_ex),
        .MemRead_ex  (mr_ex),
        .writeReg_ex (wr_ex),
        .RegWrite_mem(rw_mem),
        .MemRead_mem (mr_mem),
        .writeReg_mem(wr_mem),
        .fwd_sel_id  (fwd_sel_id),
        .stall_id    (stall_id),
        .flush_ex    (flush_ex),
        .stall_count (stall_count)
    );

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: stall cycles still owed beyond the current one, and stall tally.
    int   owed = 0;
    int   mcount = 0;
    bit   count_known = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit hit(input int k, input logic rw, input logic [REG_W-1:0] wr);
        return used[k] && rw && (wr != 0) && (src_a[k] == wr);
    endfunction

    task automatic issue();
        exp_t e;
        int   need, pn;
        e = '0;
        need = 0;
        for (int k = 0; k < NPORTS; k++) begin
            if (!reset) begin
                if (hit(k, rw_ex, wr_ex))        e.fwd[2*k +: 2] = 2'b10;
                else if (hit(k, rw_mem, wr_mem)) e.fwd[2*k +: 2] = 2'b01;
            end
            pn = 0;
            if (hit(k, rw_ex, wr_ex)) begin
                if (branch_id) pn = mr_ex ? 2 : 1;
                else           pn = mr_ex ? 1 : 0;
            end else if (branch_id && hit(k, rw_mem, wr_mem) && mr_mem) begin
                pn = 1;
            end
            if (pn > need) need = pn;
        end
        e.cnt     = CNT_W'(mcount);
        e.chk_cnt = count_known;
        if (reset) begin
            e.stall = 1'b0;
            owed = 0;
            mcount = 0;
            count_known = 1'b1;
        end else if (owed > 0) begin
            e.stall = 1'b1;
            owed--;
        end else begin
            e.stall = (need > 0);
            owed = (need > 1) ? need - 1 : 0;
        end
        if (!reset && e.stall && mcount < CMAX) mcount++;
        q.push_back(e);
    endtask

    task automatic cyc(input int r, input int br, input int s0, input int s1, input int u,
                       input int rwe, input int mre, input int we,
                       input int rwm, input int mrm, input int wm);
        @(posedge clk);
        #1;
        reset     = r[0];
        branch_id = br[0];
        src_a[0]  = REG_W'(s0);
        src_a[1]  = REG_W'(s1);
        used      = 2'(u);
        rw_ex     = rwe[0];
        mr_ex     = mre[0];
        wr_ex     = REG_W'(we);
        rw_mem    = rwm[0];
        mr_mem    = mrm[0];
        wr_mem    = REG_W'(wm);
        issue();
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("fwd_sel_id", 32'(fwd_sel_id), 32'(e.fwd));
            check("stall_id", 32'(stall_id), 32'(e.stall));
            check("flush_ex", 32'(flush_ex), 32'(e.stall));
            if (e.chk_cnt) check("stall_count", 32'(stall_count), 32'(e.cnt));
        end
    end

    initial begin
        src_a[0] = '0;
        src_a[1] = '0;
        // Reset with a branch-on-load hazard present
        cyc(1, 1, 7, 7, 3, 1, 1, 7, 0, 0, 0);
        cyc(1, 1, 7, 7, 3, 1, 1, 7, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ALU forwarding from EX and MEM; register 0 never forwards
        cyc(0, 0, 8, 9, 3, 1, 0, 8, 1, 0, 9);
        cyc(0, 0, 0, 9, 3, 1, 0, 0, 1, 0, 9);
        // Classic load-use
        cyc(0, 0, 4, 0, 1, 1, 1, 4, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Branch on EX load, then the load moves to MEM and the branch goes away
        cyc(0, 1, 0, 7, 2, 1, 1, 7, 0, 0, 0);
        cyc(0, 0, 1, 2, 0, 0, 0, 0, 1, 1, 7);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // EX over MEM priority; unused port ignored
        cyc(0, 0, 3, 3, 1, 1, 0, 3, 1, 0, 3);
        cyc(0, 1, 3, 3, 1, 1, 0, 3, 1, 1, 3);
        cyc(0, 1, 5, 6, 3, 1, 0, 5, 1, 1, 6);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Counter saturation
        for (int i = 0; i < 20; i++) cyc(0, 0, 4, 0, 1, 1, 1, 4, 0, 0, 0);
        // Reset in the middle of HOLD
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 7, 2, 1, 1, 7, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0);
        // Random traffic over a small register set to force frequent matches
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_fwd_hazard_unit.md
Name: id_fwd_hazard_unit

Overview:
- Parametrised ID-stage forwarding and hazard unit for the pipelined MIPS core.
- Selects a per-operand forwarding source for early branch compare in ID: EX result, MEM result or register file.
- Detects load-use and branch-on-load hazards and drives a stall/bubble FSM for the exact number of cycles required.
- Keeps a saturating stall-cycle performance counter. Sits beside the ID/EX pipeline register and drives the PC/IF-ID write enables and the EX bubble mux.

Parameters:
- REG_W, 5, register-index width.
- NPORTS, 2, number of ID source operands checked (port 0 = Rs, port 1 = Rt, extra ports for future 3-source ops).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- branch_id  in  1  ID instruction is a branch that compares operands in ID.
- src_id  in  NPORTS*REG_W  packed source register indices; port k = bits [k*REG_W +: REG_W].
- src_used_id  in  NPORTS  per-port flag: operand actually read.
- RegWrite_ex  in  1  EX instruction writes a register.
- MemRead_ex  in  1  EX instruction is a load.
- writeReg_ex  in  REG_W  EX destination register.
- RegWrite_mem  in  1  MEM instruction writes a register.
- MemRead_mem  in  1  MEM instruction is a load.
- writeReg_mem  in  REG_W  MEM destination register.
- fwd_sel_id  out  NPORTS*2  per-port forward select: 00 = regfile, 01 = MEM result, 10 = EX ALU result.
- stall_id  out  1  hold PC and IF/ID.
- flush_ex  out  1  insert bubble into ID/EX.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Match definitions for port k:
  - m_ex[k] = src_used_id[k] & RegWrite_ex & (writeReg_ex != 0) & (src_k == writeReg_ex)
  - m_mem[k] is the same with the MEM signals.
- Forwarding (combinational):
  - The newest producer wins: m_ex gives 10, else m_mem gives 01, else 00.
  - Both stages are considered independently. Neither requires the other to be writing.
  - Register 0 never forwards.
- Required stall cycles `need` = maximum over ports of:
  - 2: branch_id & m_ex & MemRead_ex.
  - 1: branch_id & m_ex & !MemRead_ex.
  - 1: branch_id & m_mem & MemRead_mem.
  - 1: !branch_id & m_ex & MemRead_ex (classic load-use).
  - 0 otherwise.
- FSM states:
  - IDLE: stall_id = flush_ex = (need != 0).
    - need == 2: go to HOLD with cnt = 1.
    - Otherwise stay in IDLE; the next cycle is re-evaluated.
  - HOLD: stall_id = flush_ex = 1, independent of current inputs. cnt decrements; when cnt == 1, return to IDLE. HOLD therefore lasts exactly cnt cycles.
- fwd_sel_id stays combinational in all states. While stalling it is don't-care to the datapath but must still follow the rules above.
- stall_count increments by 1 on every cycle with stall_id == 1 and saturates at all-ones (no wrap).
- Reset:
  - While reset = 1: stall_id = flush_ex = 0 and fwd_sel_id = 0.
  - Next edge: state = IDLE, cnt = 0, stall_count = 0.
  - Reset asserted in HOLD aborts the stall immediately.
- Simultaneous EX and MEM match on the same port: forward from EX. Stall is determined by the EX hazard row.
- Different ports with different needs: the maximum applies. Forwarding is still per port.
- Latency: forwarding and the first stall cycle are zero-latency (combinational). Extra stall cycles are registered.

Test Plan:
- Reset: assert reset 2 cycles with hazard inputs active -> stall_id = 0, fwd_sel_id = 0, stall_count = 0; HOLD entered before reset is left on release.
- ALU forwarding: src_id = {Rt=9, Rs=8}, EX writes 8, MEM writes 9, branch_id = 0 -> fwd_sel_id = {01,10}, no stall; writeReg_ex = 0 with Rs = 0 -> 00.
- Load-use: non-branch, Rs = 4, EX load to 4 -> stall_id = flush_ex = 1 for exactly 1 cycle; stall_count = 1.
- Branch on EX load: branch_id = 1, Rt = 7, EX load to 7, then inputs change (load moves to MEM) -> stall 2 consecutive cycles via HOLD regardless of inputs in the second cycle; stall_count = 2.
- Priority and unused ports: EX and MEM both write 3, Rs = 3 -> sel 10; src_used_id[1] = 0 with Rt matching -> port 1 sel 00, no stall.
- Saturation with CNT_W = 4: hold a load-use condition 20 cycles -> stall_count stops at 15; reset mid-HOLD -> outputs drop in the reset cycle, FSM is IDLE after.
